// File: rtl/rv32i_pkg.sv
// Shared RV32I datapath types: data width, register address type and the
// register-file write bundle used by the WB stage, the write arbiter and top.
package rv32i_pkg;

    localparam int DPW = 32;
    localparam int ADW = 5;

    typedef logic [ADW-1:0] reg_addr_t;

    typedef struct packed {
        logic             we;
        reg_addr_t        addr;
        logic [DPW-1:0]   data;
    } rf_wr_t;

    typedef enum logic {
        SERVE = 1'b0,
        FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: writeback has priority, debug writes fill free
// slots, and a starvation counter forces a one-cycle pipeline stall for debug.
module rf_wr_arbiter
    import rv32i_pkg::*;
#(
    parameter int DPW      = rv32i_pkg::DPW,
    parameter int ADW      = 5,
    parameter int MAX_WAIT = 4,
    parameter int CNTW     = 16
) (
    input  logic            clk,
    input  logic            arst_ni,
    input  logic            wb_we_i,
    input  logic [ADW-1:0]  wb_addr_i,
    input  logic [DPW-1:0]  wb_data_i,
    input  logic            dbg_valid_i,
    input  logic [ADW-1:0]  dbg_addr_i,
    input  logic [DPW-1:0]  dbg_data_i,
    output logic            dbg_ready_o,
    output logic            stall_o,
    output logic            rf_we_o,
    output logic [ADW-1:0]  rf_addr_o,
    output logic [DPW-1:0]  rf_wd_o,
    output logic [CNTW-1:0] stall_cnt_o
);

    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == {CNTW{1'b1}}) ? v : v + 1'b1;
    endfunction

    arb_state_e     state_q, state_nxt;
    logic [WW-1:0]  wait_q;
    logic           wb_act;
    logic           dbg_hs;
    logic           dbg_blocked;
    logic           wait_done;

    // A WB write to x0 is not a real write, so that slot is free for debug.
    assign wb_act      = wb_we_i & (wb_addr_i != '0);
    assign dbg_ready_o = dbg_valid_i & (stall_o | ~wb_act);
    assign dbg_hs      = dbg_ready_o;
    assign dbg_blocked = dbg_valid_i & ~dbg_ready_o;
    assign wait_done   = (wait_q == WAIT_LAST);
    assign stall_o     = (state_q == FORCE);

    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) state_q <= SERVE;
        else          state_q <= state_nxt;
    end

    // While stalled, dbg_ready_o follows dbg_valid_i, so FORCE can never repeat.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            SERVE:   if (dbg_blocked && wait_done) state_nxt = FORCE;
            FORCE:   state_nxt = SERVE;
            default: state_nxt = SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            wait_q <= '0;
        end else if (dbg_hs || !dbg_valid_i || wait_done) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            stall_cnt_o <= '0;
        end else if (state_q == SERVE && state_nxt == FORCE) begin
            stall_cnt_o <= sat_inc(stall_cnt_o);
        end
    end

    // WB inputs are ignored while stalled; the frozen pipeline re-presents them next cycle.
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            rf_we_o   <= 1'b0;
            rf_addr_o <= '0;
            rf_wd_o   <= '0;
        end else if (dbg_hs) begin
            rf_we_o   <= (dbg_addr_i != '0);
            rf_addr_o <= dbg_addr_i;
            rf_wd_o   <= dbg_data_i;
        end else if (wb_act && !stall_o) begin
            rf_we_o   <= 1'b1;
            rf_addr_o <= wb_addr_i;
            rf_wd_o   <= wb_data_i;
        end else begin
            rf_we_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: one task per scenario, inline checks, and a
// second instance with a 2-bit statistics counter for the saturation case.
module tb_rf_wr_arbiter;

    logic        clk;
    logic        arst_ni;
    logic        wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        dbg_valid_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_data_i;

    logic        dbg_ready_o, stall_o, rf_we_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_wd_o;
    logic [15:0] stall_cnt_o;

    logic        s_dbg_ready, s_stall, s_rf_we;
    logic [4:0]  s_rf_addr;
    logic [31:0] s_rf_wd;
    logic [1:0]  s_stall_cnt;

    int errors = 0;
    int checks = 0;

    rf_wr_arbiter #(.DPW(32), .ADW(5), .MAX_WAIT(4), .CNTW(16)) u_dut (
        .clk(clk), .arst_ni(arst_ni),
        .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .dbg_valid_i(dbg_valid_i), .dbg_addr_i(dbg_addr_i), .dbg_data_i(dbg_data_i),
        .dbg_ready_o(dbg_ready_o), .stall_o(stall_o),
        .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_wd_o(rf_wd_o),
        .stall_cnt_o(stall_cnt_o)
    );

    rf_wr_arbiter #(.DPW(32), .ADW(5), .MAX_WAIT(4), .CNTW(2)) u_sat (
        .clk(clk), .arst_ni(arst_ni),
        .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .dbg_valid_i(dbg_valid_i), .dbg_addr_i(dbg_addr_i), .dbg_data_i(dbg_data_i),
        .dbg_ready_o(s_dbg_ready), .stall_o(s_stall),
        .rf_we_o(s_rf_we), .rf_addr_o(s_rf_addr), .rf_wd_o(s_rf_wd),
        .stall_cnt_o(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        wb_we_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
        dbg_valid_i = 1'b0; dbg_addr_i = '0; dbg_data_i = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        arst_ni = 1'b0;
        tick();
        tick();
        checks++;
        if ({stall_o, rf_we_o, rf_addr_o, rf_wd_o, stall_cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b we=%b addr=%0d wd=%h cnt=%0d, want all 0",
                     stall_o, rf_we_o, rf_addr_o, rf_wd_o, stall_cnt_o);
        end
        arst_ni = 1'b1;
        tick();
    endtask

    task automatic test_dbg_free_slot();
        dbg_valid_i = 1'b1; dbg_addr_i = 5'd5; dbg_data_i = 32'hDEADBEEF;
        #1;
        checks++;
        if (dbg_ready_o !== 1'b1) begin
            errors++; $display("FAIL free_ready: got %b want 1", dbg_ready_o);
        end
        tick();
        dbg_valid_i = 1'b0;
        checks++;
        if ({rf_we_o, rf_addr_o, rf_wd_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL free_write: got we=%b addr=%0d wd=%h want we=1 addr=5 wd=deadbeef",
                     rf_we_o, rf_addr_o, rf_wd_o);
        end
        tick();
        checks++;
        if (rf_we_o !== 1'b0) begin
            errors++; $display("FAIL free_idle_we: got %b want 0", rf_we_o);
        end
    endtask

    task automatic test_wb_priority();
        wb_we_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'h11;
        dbg_valid_i = 1'b1; dbg_addr_i = 5'd7; dbg_data_i = 32'h77;
        #1;
        checks++;
        if (dbg_ready_o !== 1'b0) begin
            errors++; $display("FAIL prio_ready: got %b want 0", dbg_ready_o);
        end
        tick();
        idle_inputs();
        checks++;
        if ({rf_we_o, rf_addr_o, rf_wd_o} !== {1'b1, 5'd3, 32'h11}) begin
            errors++;
            $display("FAIL prio_write: got we=%b addr=%0d wd=%h want we=1 addr=3 wd=11",
                     rf_we_o, rf_addr_o, rf_wd_o);
        end
        tick();
    endtask

    task automatic test_forced_stall();
        wb_we_i = 1'b1; wb_addr_i = 5'd2; wb_data_i = 32'h22;
        dbg_valid_i = 1'b1; dbg_addr_i = 5'd9; dbg_data_i = 32'h99;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({stall_o, dbg_ready_o} !== 2'b00) begin
                errors++;
                $display("FAIL stall_blocked[%0d]: got stall=%b ready=%b want 0 0", i, stall_o, dbg_ready_o);
            end
            tick();
        end
        #1;
        checks++;
        if ({stall_o, dbg_ready_o} !== 2'b11) begin
            errors++; $display("FAIL stall_cycle: got stall=%b ready=%b want 1 1", stall_o, dbg_ready_o);
        end
        checks++;
        if ({rf_we_o, rf_addr_o} !== {1'b1, 5'd2}) begin
            errors++; $display("FAIL stall_prev_wb: got we=%b addr=%0d want we=1 addr=2", rf_we_o, rf_addr_o);
        end
        tick();
        dbg_valid_i = 1'b0;
        checks++;
        if ({stall_o, rf_we_o, rf_addr_o, rf_wd_o} !== {1'b0, 1'b1, 5'd9, 32'h99}) begin
            errors++;
            $display("FAIL stall_dbg_write: got stall=%b we=%b addr=%0d wd=%h want 0 1 9 99",
                     stall_o, rf_we_o, rf_addr_o, rf_wd_o);
        end
        tick();
        idle_inputs();
        checks++;
        if ({rf_we_o, rf_addr_o, rf_wd_o} !== {1'b1, 5'd2, 32'h22}) begin
            errors++;
            $display("FAIL stall_held_wb: got we=%b addr=%0d wd=%h want 1 2 22", rf_we_o, rf_addr_o, rf_wd_o);
        end
        checks++;
        if (stall_cnt_o !== 16'd1) begin
            errors++; $display("FAIL stall_count: got %0d want 1", stall_cnt_o);
        end
        tick();
    endtask

    task automatic test_x0_cases();
        wb_we_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'h55;
        dbg_valid_i = 1'b1; dbg_addr_i = 5'd4; dbg_data_i = 32'h44;
        #1;
        checks++;
        if (dbg_ready_o !== 1'b1) begin
            errors++; $display("FAIL x0_wb_ready: got %b want 1", dbg_ready_o);
        end
        tick();
        checks++;
        if ({rf_we_o, rf_addr_o, rf_wd_o} !== {1'b1, 5'd4, 32'h44}) begin
            errors++;
            $display("FAIL x0_wb_write: got we=%b addr=%0d wd=%h want 1 4 44", rf_we_o, rf_addr_o, rf_wd_o);
        end
        dbg_addr_i = 5'd0; dbg_data_i = 32'h66;
        #1;
        checks++;
        if (dbg_ready_o !== 1'b1) begin
            errors++; $display("FAIL x0_dbg_ready: got %b want 1", dbg_ready_o);
        end
        tick();
        idle_inputs();
        checks++;
        if (rf_we_o !== 1'b0) begin
            errors++; $display("FAIL x0_dbg_we: got %b want 0", rf_we_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        wb_we_i = 1'b1; wb_addr_i = 5'd2; wb_data_i = 32'h22;
        dbg_valid_i = 1'b1; dbg_addr_i = 5'd9; dbg_data_i = 32'h99;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (stall_o !== 1'b1) begin
            errors++; $display("FAIL rst_pre_stall: got %b want 1", stall_o);
        end
        arst_ni = 1'b0;
        #1;
        checks++;
        if ({stall_o, dbg_ready_o, rf_we_o, rf_addr_o, rf_wd_o, stall_cnt_o} !== '0) begin
            errors++;
            $display("FAIL rst_async: got stall=%b ready=%b we=%b addr=%0d wd=%h cnt=%0d want all 0",
                     stall_o, dbg_ready_o, rf_we_o, rf_addr_o, rf_wd_o, stall_cnt_o);
        end
        #1;
        arst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({stall_o, dbg_ready_o} !== 2'b00) begin
                errors++;
                $display("FAIL rst_fresh_wait[%0d]: got stall=%b ready=%b want 0 0", i, stall_o, dbg_ready_o);
            end
            tick();
        end
        #1;
        checks++;
        if ({stall_o, dbg_ready_o} !== 2'b11) begin
            errors++; $display("FAIL rst_restall: got stall=%b ready=%b want 1 1", stall_o, dbg_ready_o);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_saturation();
        int stall_cycles;
        logic prev_stall;
        arst_ni = 1'b0;
        #1;
        arst_ni = 1'b1;
        wb_we_i = 1'b1; wb_addr_i = 5'd6; wb_data_i = 32'h60;
        dbg_valid_i = 1'b1; dbg_addr_i = 5'd8; dbg_data_i = 32'h80;
        stall_cycles = 0;
        prev_stall = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (stall_o) stall_cycles++;
            if (stall_o && prev_stall) begin
                errors++; $display("FAIL sat_consecutive: stall high on two cycles at step %0d, want never", i);
            end
            prev_stall = stall_o;
        end
        checks++;
        if (stall_cycles != 5) begin
            errors++; $display("FAIL sat_stall_cycles: got %0d want 5", stall_cycles);
        end
        checks++;
        if (stall_cnt_o !== 16'd5) begin
            errors++; $display("FAIL sat_cnt16: got %0d want 5", stall_cnt_o);
        end
        checks++;
        if (s_stall_cnt !== 2'd3) begin
            errors++; $display("FAIL sat_cnt2: got %0d want 3", s_stall_cnt);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_dbg_free_slot();
        test_wb_priority();
        test_forced_stall();
        test_x0_cases();
        test_reset_mid_stall();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
